// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_if
// Purpose  : Issue/completion bundle between an integer issue slot and its
//            alu_muldiv_unit.
// Signals  : flush, in_valid, in1, in2, func, in_tag   (issue -> unit)
//            in_ready, out_valid, result, out_tag      (unit -> issue)
// Revision : 1.0  initial release
// ============================================================================
interface alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       func;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;

  // Issue-stage side.
  modport master (
    output flush, in_valid, in1, in2, func, in_tag,
    input  in_ready, out_valid, result, out_tag
  );

  // Execution-unit side.
  modport slave (
    input  flush, in_valid, in1, in2, func, in_tag,
    output in_ready, out_valid, result, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_unit
// Purpose  : Integer execution unit: registered single-cycle ALU ops, iterative
//            signed/unsigned multiply and divide into HI/LO, MFHI/MFLO reads.
//            A tag travels with each operation to its completion pulse.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            io   - alu_muldiv_if.slave (request, handshake, result, tags)
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  alu_muldiv_if.slave        io
);

  localparam logic [3:0] FN_AND   = 4'b0000;
  localparam logic [3:0] FN_OR    = 4'b0001;
  localparam logic [3:0] FN_XOR   = 4'b0010;
  localparam logic [3:0] FN_XNOR  = 4'b0011;
  localparam logic [3:0] FN_ADD   = 4'b0100;
  localparam logic [3:0] FN_SUB   = 4'b1100;
  localparam logic [3:0] FN_SLT   = 4'b1101;
  localparam logic [3:0] FN_SLTU  = 4'b0110;
  localparam logic [3:0] FN_MFHI  = 4'b0111;
  localparam logic [3:0] FN_MFLO  = 4'b1110;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fin;        // all iterations done; next BUSY edge fixes signs
  logic             is_div;
  logic             neg_lo;     // product / quotient must be negated
  logic             neg_hi;     // remainder must be negated
  logic             div_zero;
  logic [WIDTH-1:0] a_orig;     // raw dividend, HI value on divide by zero
  logic [WIDTH-1:0] b_mag;      // multiplicand / divisor magnitude
  logic [WIDTH:0]   acc;        // product high half / partial remainder
  logic [WIDTH-1:0] work;       // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [TAG_W-1:0] busy_tag;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [TAG_W-1:0] out_tag_r;

  assign io.in_ready  = (state != BUSY);
  assign io.out_valid = out_valid_r;
  assign io.result    = result_r;
  assign io.out_tag   = out_tag_r;

  // Request decode
  logic             accept;
  logic             is_multi;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH-1:0] alu_res;

  assign accept   = io.in_valid && io.in_ready && !io.flush;
  assign is_multi = (io.func[3:2] == 2'b10);
  // Odd multi-cycle codes (MULT, DIV) are the signed variants.
  assign a_neg    = io.func[0] && io.in1[WIDTH-1];
  assign b_neg    = io.func[0] && io.in2[WIDTH-1];
  assign a_mag    = a_neg ? -io.in1 : io.in1;
  assign b_mag_in = b_neg ? -io.in2 : io.in2;

  always_comb begin
    alu_res = '0;
    case (io.func)
      FN_AND:  alu_res = io.in1 & io.in2;
      FN_OR:   alu_res = io.in1 | io.in2;
      FN_XOR:  alu_res = io.in1 ^ io.in2;
      FN_XNOR: alu_res = ~(io.in1 ^ io.in2);
      FN_ADD:  alu_res = io.in1 + io.in2;
      FN_SUB:  alu_res = io.in1 - io.in2;
      FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(io.in1) < $signed(io.in2))};
      FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (io.in1 < io.in2)};
      FN_MFHI: alu_res = hi;   // in DONE, hi already holds the just-finished value
      FN_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign mul_sum  = acc + (work[0] ? {1'b0, b_mag} : '0);
  assign div_sh   = {acc[WIDTH-1:0], work[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_mag};
  assign div_ge   = (div_sh >= {1'b0, b_mag});

  // Sign fix-up and special cases at completion
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign prod_mag = {acc[WIDTH-1:0], work};
  assign prod_fix = neg_lo ? -prod_mag : prod_mag;
  assign q_fix    = neg_lo ? -work : work;
  assign r_fix    = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  // The most-negative / -1 case needs no special handling: the magnitude
  // quotient is 2^(WIDTH-1), whose negation wraps back to itself, remainder 0.
  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fin_hi = a_orig;
        fin_lo = '1;
      end else begin
        fin_hi = r_fix;
        fin_lo = q_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      fin         <= 1'b0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      div_zero    <= 1'b0;
      a_orig      <= '0;
      b_mag       <= '0;
      acc         <= '0;
      work        <= '0;
      hi          <= '0;
      lo          <= '0;
      busy_tag    <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      out_tag_r   <= '0;
    end else begin
      out_valid_r <= 1'b0;
      if (io.flush) begin
        // Abandon any in-flight op; HI/LO keep their last committed values.
        state <= IDLE;
        cnt   <= '0;
        fin   <= 1'b0;
      end else begin
        case (state)
          BUSY: begin
            if (!fin) begin
              if (is_div) begin
                acc  <= div_ge ? div_diff : div_sh;
                work <= {work[WIDTH-2:0], div_ge};
              end else begin
                acc  <= {1'b0, mul_sum[WIDTH:1]};
                work <= {mul_sum[0], work[WIDTH-1:1]};
              end
              if (cnt == CNT_LAST) begin
                fin <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              hi          <= fin_hi;
              lo          <= fin_lo;
              result_r    <= fin_lo;
              out_tag_r   <= busy_tag;
              out_valid_r <= 1'b1;
              fin         <= 1'b0;
              cnt         <= '0;
              state       <= DONE;
            end
          end
          default: begin  // IDLE or DONE: both accept new work
            state <= IDLE;
            if (accept) begin
              if (is_multi) begin
                state    <= BUSY;
                cnt      <= '0;
                fin      <= 1'b0;
                is_div   <= io.func[1];
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= a_neg;
                div_zero <= (io.in2 == '0);
                a_orig   <= io.in1;
                b_mag    <= b_mag_in;
                acc      <= '0;
                work     <= a_mag;
                busy_tag <= io.in_tag;
              end else begin
                result_r    <= alu_res;
                out_tag_r   <= io.in_tag;
                out_valid_r <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_unit
// Purpose  : Self-checking bench for alu_muldiv_unit: directed scenarios plus
//            randomized ops compared against a plain-arithmetic HI/LO model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_unit;
  localparam int WIDTH = 32;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
  alu_muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .io(bus));

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m, lo_m;

  // Reference model: MIPS semantics in plain 64-bit arithmetic.
  task automatic model_exec(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 32'h0;
    case (f)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a ^ b;
      4'b0011: res = ~(a ^ b);
      4'b0100: res = a + b;
      4'b1100: res = a - b;
      4'b1101: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0110: res = (a < b) ? 32'd1 : 32'd0;
      4'b0111: res = hi_m;
      4'b1110: res = lo_m;
      4'b1001: begin p = sa * sb; {hi_m, lo_m} = p; res = lo_m; end
      4'b1000: begin up = {32'h0, a} * {32'h0, b}; {hi_m, lo_m} = up; res = lo_m; end
      4'b1011: begin
        if (b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo_m = a; hi_m = 0; end
        else begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
        res = lo_m;
      end
      4'b1010: begin
        if (b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
        res = lo_m;
      end
      default: res = 32'h0;
    endcase
  endtask

  // Present one request for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tg);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = f; bus.in1 = a; bus.in2 = b; bus.in_tag = tg;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for a completion pulse; lat=0 means it never came.
  task automatic wait_done(output int lat, output logic [31:0] res, output logic [TAG_W-1:0] tg,
                           output bit rdy_seen);
    lat = 0; res = 0; tg = 0;
    rdy_seen = bus.in_ready;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k; res = bus.result; tg = bus.out_tag;
        break;
      end
      if (bus.in_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.in1 = 0; bus.in2 = 0; bus.func = 0; bus.in_tag = 0;
    hi_m = 0; lo_m = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); end
    @(negedge clk);
    rst = 1'b0;
    issue(4'b0111, 0, 0, 6'd1);
    checks++; if (bus.result !== 32'h0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL reset_hi got=%h/%b exp=0/1", bus.result, bus.out_valid); end
    issue(4'b1110, 0, 0, 6'd2);
    checks++; if (bus.result !== 32'h0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL reset_lo got=%h/%b exp=0/1", bus.result, bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4];
    exp_v = '{32'hFF000000, 32'hFFFFFF00, 32'h00FFFF00, 32'hFF0000FF};
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 32'hFFFF0000, 32'hFF00FF00, 6'(i + 1));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp_v[i] || bus.out_tag !== 6'(i + 1)) begin
        errors++;
        $display("FAIL b2b_logic[%0d] got v=%b r=%h t=%0d exp v=1 r=%h t=%0d",
                 i, bus.out_valid, bus.result, bus.out_tag, exp_v[i], i + 1);
      end
    end
  endtask

  task automatic test_arith();
    issue(4'b0100, 32'd78375, 32'd42596, 6'd5);
    checks++; if (bus.result !== 32'h0001D88B) begin errors++; $display("FAIL add got=%h exp=0001d88b", bus.result); end
    issue(4'b1100, 32'd78375, 32'd42596, 6'd6);
    checks++; if (bus.result !== 32'h00008BC3) begin errors++; $display("FAIL sub got=%h exp=00008bc3", bus.result); end
    issue(4'b1101, 32'hFFFFFFFF, 32'h0000000F, 6'd7);
    checks++; if (bus.result !== 32'h1) begin errors++; $display("FAIL slt got=%h exp=1", bus.result); end
    issue(4'b0110, 32'hFFFFFFFF, 32'h0000000F, 6'd8);
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL sltu got=%h exp=0", bus.result); end
    issue(4'b0101, 32'h1234, 32'h5678, 6'd9);
    checks++; if (bus.result !== 32'h0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL reserved got=%h/%b exp=0/1", bus.result, bus.out_valid); end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r; logic [TAG_W-1:0] t; bit rdy; logic [31:0] m;
    issue(4'b1001, 32'hFFFFFFFE, 32'h3, 6'd9);
    model_exec(4'b1001, 32'hFFFFFFFE, 32'h3, m);
    wait_done(lat, r, t, rdy);
    checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL mult_latency got=%0d exp=%0d", lat, WIDTH + 1); end
    checks++; if (rdy) begin errors++; $display("FAIL mult_in_ready_busy got=1 exp=0"); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mult_in_ready_done got=%b exp=1", bus.in_ready); end
    checks++; if (r !== 32'hFFFFFFFA || t !== 6'd9) begin errors++; $display("FAIL mult_result got=%h/%0d exp=fffffffa/9", r, t); end
    // MFHI issued so that it is accepted in the DONE cycle.
    issue(4'b0111, 0, 0, 6'd10);
    checks++; if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.result); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 6'd10) begin errors++; $display("FAIL mfhi_pulse got=%b/%0d exp=1/10", bus.out_valid, bus.out_tag); end
    issue(4'b1000, 32'hFFFFFFFE, 32'h3, 6'd11);
    model_exec(4'b1000, 32'hFFFFFFFE, 32'h3, m);
    wait_done(lat, r, t, rdy);
    checks++; if (r !== 32'hFFFFFFFA || lat != WIDTH + 1) begin errors++; $display("FAIL multu_lo got=%h lat=%0d exp=fffffffa lat=%0d", r, lat, WIDTH + 1); end
    issue(4'b0111, 0, 0, 6'd12);
    checks++; if (bus.result !== 32'h00000002) begin errors++; $display("FAIL multu_hi got=%h exp=00000002", bus.result); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] r; logic [TAG_W-1:0] t; bit rdy; logic [31:0] m;
    logic [31:0] a_v [3]; logic [31:0] b_v [3]; logic [3:0] f_v [3];
    logic [31:0] lo_v [3]; logic [31:0] hi_v [3];
    a_v = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    b_v = '{32'd2, 32'd0, 32'hFFFFFFFF};
    f_v = '{4'b1011, 4'b1010, 4'b1011};
    lo_v = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    hi_v = '{32'hFFFFFFFF, 32'h00000007, 32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(f_v[i], a_v[i], b_v[i], 6'(20 + i));
      model_exec(f_v[i], a_v[i], b_v[i], m);
      wait_done(lat, r, t, rdy);
      checks++;
      if (r !== lo_v[i] || t !== 6'(20 + i) || lat != WIDTH + 1) begin
        errors++;
        $display("FAIL div_lo[%0d] got=%h t=%0d lat=%0d exp=%h t=%0d lat=%0d", i, r, t, lat, lo_v[i], 20 + i, WIDTH + 1);
      end
      issue(4'b0111, 0, 0, 6'd30);
      checks++; if (bus.result !== hi_v[i]) begin errors++; $display("FAIL div_hi[%0d] got=%h exp=%h", i, bus.result, hi_v[i]); end
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] r; logic [TAG_W-1:0] t; bit rdy; logic [31:0] m; int seen;
    issue(4'b1010, 32'd100, 32'd7, 6'd40);
    model_exec(4'b1010, 32'd100, 32'd7, m);
    wait_done(lat, r, t, rdy);
    checks++; if (r !== 32'h0E) begin errors++; $display("FAIL divu_100_7 got=%h exp=0000000e", r); end
    issue(4'b1010, 32'd50, 32'd3, 6'd41);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_state got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid); end
    seen = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_pulse got=%0d pulses exp=0", seen); end
    issue(4'b1110, 0, 0, 6'd42);
    checks++; if (bus.result !== 32'h0E) begin errors++; $display("FAIL flush_lo got=%h exp=0000000e", bus.result); end
    issue(4'b0111, 0, 0, 6'd43);
    checks++; if (bus.result !== 32'h02) begin errors++; $display("FAIL flush_hi got=%h exp=00000002", bus.result); end
    // A request presented together with flush is dropped.
    @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.func = 4'b0100; bus.in1 = 1; bus.in2 = 2; bus.in_tag = 6'd44;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    issue(4'b1001, 32'h12345678, 32'h9ABCDEF0, 6'd50);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b v=%b r=%h t=%0d exp 1/0/0/0", bus.in_ready, bus.out_valid, bus.result, bus.out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    hi_m = 0; lo_m = 0;
    issue(4'b0100, 32'd5, 32'd6, 6'd51);
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd11 || bus.out_tag !== 6'd51) begin errors++; $display("FAIL add_after_reset got v=%b r=%h t=%0d exp 1/b/51", bus.out_valid, bus.result, bus.out_tag); end
    issue(4'b0111, 0, 0, 6'd52);
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL hi_after_reset got=%h exp=0", bus.result); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat; logic [31:0] r; logic [TAG_W-1:0] t; bit rdy;
    logic [3:0] f; logic [31:0] a, b, e; logic [TAG_W-1:0] tg;
    for (int i = 0; i < 60; i++) begin
      f = 4'($urandom_range(0, 15));
      a = pick_operand(); b = pick_operand();
      if ($urandom_range(0, 3) == 0) b = 32'(-$signed(32'($urandom_range(1, 9))));
      tg = 6'($urandom);
      issue(f, a, b, tg);
      model_exec(f, a, b, e);
      if (f[3:2] == 2'b10) begin
        wait_done(lat, r, t, rdy);
        checks++;
        if (r !== e || t !== tg || lat != WIDTH + 1 || rdy) begin
          errors++;
          $display("FAIL rand_multi[%0d] f=%b a=%h b=%h got=%h t=%0d lat=%0d exp=%h t=%0d lat=%0d", i, f, a, b, r, t, lat, e, tg, WIDTH + 1);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== e || bus.out_tag !== tg) begin
          errors++;
          $display("FAIL rand_single[%0d] f=%b a=%h b=%h got v=%b r=%h t=%0d exp r=%h t=%0d", i, f, a, b, bus.out_valid, bus.result, bus.out_tag, e, tg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
